// File: rtl/tow_scoreboard_if.sv
// Signal bundle between the tug-of-war playfield and its scoreboard.
// The playfield side drives the pulls and end-light status; the scoreboard returns score and round control.
interface tow_scoreboard_if;
  logic       L;
  logic       R;
  logic       leftOn;
  logic       rightOn;
  logic       roundReset;
  logic [6:0] hexL;
  logic [6:0] hexR;
  logic       matchOver;
  logic [1:0] winner;

  modport master (
    output L, R, leftOn, rightOn,
    input  roundReset, hexL, hexR, matchOver, winner
  );

  modport slave (
    input  L, R, leftOn, rightOn,
    output roundReset, hexL, hexR, matchOver, winner
  );
endinterface

// File: rtl/tow_scoreboard.sv
// Match-level scorekeeper for the tug-of-war game: scores round wins, holds each point on the
// displays for a while, then pulses roundReset to restart the playfield, until one side reaches WIN_SCORE.
module tow_scoreboard #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 25
) (
  input logic             clk,
  input logic             reset,
  tow_scoreboard_if.slave tow
);

  typedef enum logic [1:0] {PLAY, HOLD, RESTART, DONE} state_t;

  localparam logic [2:0]       WIN       = 3'(WIN_SCORE);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Active-low seven-segment pattern, bit order gfedcba.
  function automatic logic [6:0] seg(input logic [2:0] d);
    logic [6:0] s;
    case (d)
      3'd0:    s = 7'b1000000;
      3'd1:    s = 7'b1111001;
      3'd2:    s = 7'b0100100;
      3'd3:    s = 7'b0110000;
      3'd4:    s = 7'b0011001;
      3'd5:    s = 7'b0010010;
      3'd6:    s = 7'b0000010;
      default: s = 7'b1111000;
    endcase
    return s;
  endfunction

  state_t           state;
  logic [2:0]       score_l;
  logic [2:0]       score_r;
  logic [CNT_W-1:0] cnt;
  logic             left_point;
  logic             right_point;

  // Simultaneous pulls cancel on the playfield, so each point excludes the opposite pull.
  always_comb begin
    left_point  = tow.leftOn  & tow.L & ~tow.R;
    right_point = tow.rightOn & tow.R & ~tow.L;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= PLAY;
      score_l        <= '0;
      score_r        <= '0;
      cnt            <= '0;
      tow.roundReset <= 1'b0;
      tow.matchOver  <= 1'b0;
      tow.winner     <= '0;
      tow.hexL       <= seg(3'd0);
      tow.hexR       <= seg(3'd0);
    end else begin
      tow.roundReset <= 1'b0;
      case (state)
        PLAY: begin
          if (left_point ^ right_point) begin
            if (left_point) begin
              score_l  <= score_l + 3'd1;
              tow.hexL <= seg(score_l + 3'd1);
            end else begin
              score_r  <= score_r + 3'd1;
              tow.hexR <= seg(score_r + 3'd1);
            end
            cnt   <= HOLD_LOAD;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            if (score_l == WIN || score_r == WIN) begin
              state         <= DONE;
              tow.matchOver <= 1'b1;
              tow.winner    <= {score_r == WIN, score_l == WIN};
            end else begin
              // roundReset is registered here so it is high during the RESTART cycle itself.
              state          <= RESTART;
              tow.roundReset <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        RESTART: state <= PLAY;
        DONE:    state <= DONE;
        default: state <= PLAY;
      endcase
    end
  end

endmodule

// File: doc/tow_scoreboard.md
Name: tow_scoreboard

Overview:
- Match-level scorekeeper that sits directly downstream of the tug-of-war playfield (the nine-LED light chain and the conditioned pull pulses).
- Detects when a player wins a round, increments that player's score and holds the result for a visible interval.
- Issues a one-cycle round-restart pulse; the top level ORs this pulse into the playfield reset.
- Ends the match when a player reaches WIN_SCORE. Scores are shown on two seven-segment displays.

Parameters:
- WIN_SCORE, 7, points needed to win the match. Legal range 1..7.
- HOLD_CYCLES, 4, number of cycles the scored point is held before the round restarts. Legal range >= 1. The board build sets 25_000_000 (0.5 s).
- CNT_W, 25, width of the hold counter. Must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- reset  in  1  asynchronous, active-low reset. Low means reset.
- L  in  1  left pull pulse, one cycle wide, from the left press conditioner.
- R  in  1  right pull pulse, one cycle wide, from the right press conditioner.
- leftOn  in  1  leftmost playfield light is lit (LEDR[9]).
- rightOn  in  1  rightmost playfield light is lit (LEDR[1]).
- roundReset  out  1  one-cycle pulse that restarts the playfield.
- hexL  out  7  left score, active-low seven-segment, bit order gfedcba.
- hexR  out  7  right score, same encoding as hexL.
- matchOver  out  1  high once a player reaches WIN_SCORE.
- winner  out  2  01 = left won, 10 = right won, 00 = no winner yet.

Behaviour:
- All outputs are registered.
- On reset low (asynchronous):
  - state = PLAY, both scores = 0, counter = 0.
  - roundReset = 0, matchOver = 0, winner = 00.
  - hexL = hexR = 1000000 (digit 0).
- Segment encoding, active-low, gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
- Scores are 3 bits wide and never exceed WIN_SCORE.
- Point conditions:
  - leftPoint = leftOn & L & ~R.
  - rightPoint = rightOn & R & ~L.
  - L and R high in the same cycle gives no point, because the playfield cancels simultaneous pulls.
- PLAY state:
  - On leftPoint: at that edge, scoreL += 1, counter = HOLD_CYCLES-1, next state = HOLD. rightPoint is symmetric.
  - leftPoint and rightPoint cannot both be true in the same cycle; if they were, neither scores.
  - No other input has any effect.
- HOLD state:
  - L and R are ignored, so presses during the hold never score.
  - Counter decrements by one each cycle.
  - In the cycle where the counter is 0:
    - If either score == WIN_SCORE, next state = DONE, and matchOver = 1 and winner are set at that edge.
    - Otherwise next state = RESTART.
- RESTART state:
  - roundReset = 1 for exactly this one cycle; next state = PLAY.
  - L, R, leftOn and rightOn are ignored, since the playfield is still settling.
- DONE state:
  - Terminal; all inputs ignored. The displays hold the final scores.
  - roundReset stays 0. Only reset leaves DONE.
- hexL and hexR update on the same edge as the score register.
- Latency:
  - From a point pulse to hex update: 1 cycle.
  - From a point pulse to the roundReset pulse: HOLD_CYCLES+1 cycles.
- Reset mid-operation (in HOLD or RESTART): reset takes effect immediately. Scores clear and no roundReset pulse is emitted.
- leftOn and rightOn both high is illegal playfield state. In that case, L & ~R scores left and R & ~L scores right, per the point conditions above.

Test Plan:
- Reset low, then release; leftOn=0, rightOn=0; toggle L and R -> hexL=hexR=1000000, roundReset=0, winner=00 throughout.
- leftOn=1, single L pulse, HOLD_CYCLES=4 -> next cycle hexL=1111001; roundReset high for exactly 1 cycle, 5 cycles after the pulse; state returns to PLAY.
- rightOn=1, with L and R high in the same cycle -> no score change and no roundReset; then an R-only pulse -> hexR=1111001.
- During HOLD, pulse L 3 times while leftOn=1 -> scoreL increments only once (hexL=1111001).
- WIN_SCORE=3, three left points -> after the third hold: matchOver=1, winner=01, hexL=0110000, no roundReset. Further pulses change nothing until reset.
- Assert reset low in the middle of HOLD after scoring -> asynchronous clear: hexL=1000000, roundReset never pulses, and after release state is PLAY.
